// File: rtl/edgcol_dispatch.sv
// Edge-collision accelerator dispatcher: edge register file, start snapshot, launch/wait handshake.
// Define EDGCOL_DISPATCH_TIMEOUT_EN to abort a WAIT lasting TIMEOUT_CYCLES and flag it on timeout.
module edgcol_dispatch #(
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned NUM_EDGE_REGS  = 6,
    parameter int unsigned RESULT_WIDTH   = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               rstb,
    input  logic                               wr_ena,
    input  logic [$clog2(NUM_EDGE_REGS)-1:0]   wr_addr,
    input  logic [BUS_WIDTH-1:0]               wr_data,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic                               timeout,
    output logic [BUS_WIDTH-1:0]               result_lo,
    output logic [BUS_WIDTH-1:0]               result_hi,
    output logic                               acc_start,
    input  logic                               acc_done,
    input  logic [RESULT_WIDTH-1:0]            acc_return,
    output logic [NUM_EDGE_REGS*BUS_WIDTH-1:0] edge_bus
);

    localparam int unsigned AW = $clog2(NUM_EDGE_REGS);
    localparam logic [AW:0] NREGS = NUM_EDGE_REGS[AW:0];

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StComplete} state_e;

    state_e                             state_q, state_d;
    logic [NUM_EDGE_REGS*BUS_WIDTH-1:0] edge_q;
    logic [NUM_EDGE_REGS*BUS_WIDTH-1:0] snap_q;
    logic [RESULT_WIDTH-1:0]            result_q;
    logic                               capture;
    logic                               wait_expired;
    logic                               wr_ok;
    logic                               accept;

    assign busy      = (state_q == StLaunch) || (state_q == StWait);
    assign done      = (state_q == StComplete);
    assign acc_start = (state_q == StLaunch);
    assign accept    = (state_q == StIdle) && start;
    assign wr_ok     = wr_ena && !busy && ({1'b0, wr_addr} < NREGS);

    assign edge_bus  = snap_q;
    assign result_lo = result_q[BUS_WIDTH-1:0];
    assign result_hi = result_q[RESULT_WIDTH-1:BUS_WIDTH];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLaunch;
            end
            StLaunch: begin
                // A return already present during launch is taken immediately.
                if (acc_done) begin
                    capture = 1'b1;
                    state_d = StComplete;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (acc_done) begin
                    capture = 1'b1;
                    state_d = StComplete;
                end else if (wait_expired) begin
                    state_d = StComplete;
                end
            end
            StComplete: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Snapshot takes the pre-write register contents when start and a write coincide.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            edge_q <= '0;
            snap_q <= '0;
        end else begin
            if (wr_ok) begin
                for (int i = 0; i < NUM_EDGE_REGS; i++) begin
                    if (wr_addr == AW'(i)) edge_q[i*BUS_WIDTH +: BUS_WIDTH] <= wr_data;
                end
            end
            if (accept) snap_q <= edge_q;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            result_q <= '0;
        end else if (capture) begin
            result_q <= acc_return;
        end
    end

`ifdef EDGCOL_DISPATCH_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_CYCLES[15:0] - 16'd1;

    logic [15:0] cnt_q;
    logic        timeout_q;

    // cnt_q counts completed WAIT cycles; the last allowed one expires the wait.
    assign wait_expired = (state_q == StWait) && (cnt_q == TIMEOUT_LAST);
    assign timeout      = timeout_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == StWait) ? cnt_q + 16'd1 : 16'd0;
            if (capture) begin
                timeout_q <= 1'b0;
            end else if (wait_expired && !acc_done) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign wait_expired          = 1'b0;
    assign timeout               = 1'b0;
`endif

endmodule

// File: tb/tb_edgcol_dispatch.sv
// Directed, table-driven bench for edgcol_dispatch (6 x 32-bit edge registers, 64-bit result).
module tb_edgcol_dispatch;

    localparam int BW = 32;
    localparam int NR = 6;

    logic            clk;
    logic            rstb;
    logic            wr_ena;
    logic [2:0]      wr_addr;
    logic [BW-1:0]   wr_data;
    logic            start;
    logic            busy;
    logic            done;
    logic            timeout;
    logic [BW-1:0]   result_lo;
    logic [BW-1:0]   result_hi;
    logic            acc_start;
    logic            acc_done;
    logic [2*BW-1:0] acc_return;
    logic [NR*BW-1:0] edge_bus;

    int total = 0;
    int bad   = 0;

    edgcol_dispatch #(
        .BUS_WIDTH      (BW),
        .NUM_EDGE_REGS  (NR),
        .RESULT_WIDTH   (2 * BW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .wr_ena     (wr_ena),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .result_lo  (result_lo),
        .result_hi  (result_hi),
        .acc_start  (acc_start),
        .acc_done   (acc_done),
        .acc_return (acc_return),
        .edge_bus   (edge_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            we;
        logic [2:0]      addr;
        logic [BW-1:0]   data;
        logic            st;
        logic            ad;
        logic [2*BW-1:0] ret;
        logic            busy;
        logic            done;
        logic            as;
        logic [BW-1:0]   lo;
        logic [BW-1:0]   hi;
        logic            chk_bus;
        logic [NR*BW-1:0] bus;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t v(input logic we, input logic [2:0] addr, input logic [BW-1:0] data,
                               input logic st, input logic ad, input logic [2*BW-1:0] ret,
                               input logic b, input logic d, input logic as,
                               input logic [BW-1:0] lo, input logic [BW-1:0] hi,
                               input logic cb, input logic [NR*BW-1:0] bus);
        vec_t r;
        r.we = we; r.addr = addr; r.data = data; r.st = st; r.ad = ad; r.ret = ret;
        r.busy = b; r.done = d; r.as = as; r.lo = lo; r.hi = hi; r.chk_bus = cb; r.bus = bus;
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_ena = 0; wr_addr = 0; wr_data = 0; start = 0; acc_done = 0; acc_return = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR*BW-1:0] bus_a;
        logic [NR*BW-1:0] bus_b;
        logic [BW-1:0]    prev_lo;
        logic [BW-1:0]    prev_hi;
        bus_a = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        bus_b = {32'd6, 32'd5, 32'd4, 32'hAA, 32'd2, 32'd1};

        vecs[0]  = v(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, '0);
        vecs[1]  = v(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        vecs[2]  = v(1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        vecs[3]  = v(1, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        vecs[4]  = v(1, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        vecs[5]  = v(1, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, '0);
        vecs[6]  = v(0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, bus_a);
        vecs[7]  = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, bus_a);
        vecs[8]  = v(0, 0, 0, 0, 1, 64'h0000_0001_0000_0000, 0, 1, 0, 0, 1, 1, bus_a);
        vecs[9]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0);
        vecs[10] = v(1, 7, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0);
        vecs[11] = v(1, 2, 32'hAA, 1, 0, 0, 1, 0, 1, 0, 1, 1, bus_a);
        vecs[12] = v(1, 0, 32'hFF, 1, 0, 0, 1, 0, 0, 0, 1, 1, bus_a);
        vecs[13] = v(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1, bus_a);
        vecs[14] = v(0, 0, 0, 0, 1, 64'h0000_0000_1234_5678, 0, 1, 0, 32'h1234_5678, 0, 1, bus_a);
        vecs[15] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0, 0, '0);
        vecs[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0, 0, '0);
        vecs[17] = v(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 32'h1234_5678, 0, 0, '0);
        vecs[18] = v(0, 0, 0, 1, 0, 0, 1, 0, 1, 32'h1234_5678, 0, 1, bus_b);
        vecs[19] = v(0, 0, 0, 0, 1, 64'hCAFE_F00D_0BAD_BEEF, 0, 1, 0, 32'h0BAD_BEEF,
                     32'hCAFE_F00D, 1, bus_b);
        vecs[20] = v(0, 0, 0, 0, 1, 64'h1111_2222_3333_4444, 0, 0, 0, 32'h0BAD_BEEF,
                     32'hCAFE_F00D, 1, bus_b);

        // Reset state
        idle_inputs();
        rstb = 1'b0;
        #2;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset timeout", timeout, 0);
        check("reset acc_start", acc_start, 0);
        check("reset result", {result_hi, result_lo}, 0);
        check("reset edge_bus", edge_bus, 0);
        #10 rstb = 1'b1;
        tick();

        // Cycle-by-cycle vectors
        for (int i = 0; i < 21; i++) begin
            wr_ena = vecs[i].we; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
            start = vecs[i].st; acc_done = vecs[i].ad; acc_return = vecs[i].ret;
            tick();
            check($sformatf("row%0d busy", i), busy, vecs[i].busy);
            check($sformatf("row%0d done", i), done, vecs[i].done);
            check($sformatf("row%0d acc_start", i), acc_start, vecs[i].as);
            check($sformatf("row%0d result_lo", i), result_lo, vecs[i].lo);
            check($sformatf("row%0d result_hi", i), result_hi, vecs[i].hi);
            check($sformatf("row%0d timeout", i), timeout, 0);
            if (vecs[i].chk_bus) check($sformatf("row%0d edge_bus", i), edge_bus, vecs[i].bus);
        end
        idle_inputs();
        tick();

        // Reset in WAIT, then a late acc_done after release
        start = 1; tick(); start = 0;
        tick();
        check("mid-op in wait", busy, 1);
        rstb = 1'b0;
        #1;
        check("mid-op reset busy", busy, 0);
        check("mid-op reset done", done, 0);
        check("mid-op reset result", {result_hi, result_lo}, 0);
        check("mid-op reset edge_bus", edge_bus, 0);
        tick();
        rstb = 1'b1;
        tick();
        acc_done = 1; acc_return = 64'h7777_8888_9999_AAAA;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("late acc_done done c%0d", k), done, 0);
            check($sformatf("late acc_done busy c%0d", k), busy, 0);
            check($sformatf("late acc_done result c%0d", k), {result_hi, result_lo}, 0);
        end
        idle_inputs();
        tick();

        // Good op with return during LAUNCH
        start = 1; tick(); start = 0;
        acc_done = 1; acc_return = 64'h5555_0000_AAAA_1111;
        tick();
        acc_done = 0;
        check("good op done", done, 1);
        check("good op result", {result_hi, result_lo}, 64'h5555_0000_AAAA_1111);
        tick();
        prev_lo = 32'hAAAA_1111;
        prev_hi = 32'h5555_0000;

`ifdef EDGCOL_DISPATCH_TIMEOUT_EN
        // Abort after four WAIT cycles
        start = 1; tick(); start = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("timeout wait c%0d busy", k), busy, 1);
            check($sformatf("timeout wait c%0d done", k), done, 0);
        end
        tick();
        check("timeout done", done, 1);
        check("timeout flag", timeout, 1);
        check("timeout result_lo held", result_lo, prev_lo);
        check("timeout result_hi held", result_hi, prev_hi);
        tick();
        check("timeout sticky", timeout, 1);
        start = 1; tick(); start = 0;
        tick();
        acc_done = 1; acc_return = 64'h0123_4567_89AB_CDEF;
        tick();
        acc_done = 0;
        check("recover done", done, 1);
        check("recover timeout cleared", timeout, 0);
        check("recover result", {result_hi, result_lo}, 64'h0123_4567_89AB_CDEF);
        tick();
`else
        // Without the timeout feature WAIT persists
        start = 1; tick(); start = 0;
        for (int k = 0; k < 12; k++) tick();
        check("long wait busy", busy, 1);
        check("long wait done", done, 0);
        check("long wait timeout", timeout, 0);
        check("long wait result_lo held", result_lo, prev_lo);
        check("long wait result_hi held", result_hi, prev_hi);
        acc_done = 1; acc_return = 64'h0123_4567_89AB_CDEF;
        tick();
        acc_done = 0;
        check("long wait done", done, 1);
        check("long wait result", {result_hi, result_lo}, 64'h0123_4567_89AB_CDEF);
        tick();
        check("long wait done drops", done, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edgcol_dispatch.md
EDGCOL_DISPATCH -- requirements
Module: edgcol_dispatch

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, data width of edge registers and result words.
REQ-002 SHALL have parameter NUM_EDGE_REGS, default 6, number of edge coordinate registers (legal range 2..16).
REQ-003 SHALL have parameter RESULT_WIDTH, default 64, accelerator return width (must equal 2*BUS_WIDTH).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles before abort (legal range 1..65535).
REQ-005 SHALL have port clk, input, 1, the single clock; all state is rising-edge.
REQ-006 SHALL have port rstb, input, 1, reset: asynchronous and active-low.
REQ-007 SHALL have port wr_ena, input, 1, edge register write strobe.
REQ-008 SHALL have port wr_addr, input, clog2(NUM_EDGE_REGS), edge register index.
REQ-009 SHALL have port wr_data, input, BUS_WIDTH, edge register write value.
REQ-010 SHALL have port start, input, 1, request to launch one collision check.
REQ-011 SHALL have port busy, output, 1, high from accepted start until done pulse; core stall.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port timeout, output, 1, sticky flag: last operation aborted.
REQ-014 SHALL have ports result_lo and result_hi, output, BUS_WIDTH each, captured return bits [BUS_WIDTH-1:0] and [RESULT_WIDTH-1:BUS_WIDTH].
REQ-015 SHALL have port acc_start, output, 1, accelerator ap_start level.
REQ-016 SHALL have port acc_done, input, 1, accelerator ap_done.
REQ-017 SHALL have port acc_return, input, RESULT_WIDTH, accelerator return value.
REQ-018 SHALL have port edge_bus, output, NUM_EDGE_REGS*BUS_WIDTH, snapshot registers, register i at bits [i*BUS_WIDTH +: BUS_WIDTH].

Function
REQ-019 SHALL write wr_data into edge register wr_addr on clk when wr_ena high, busy low, and wr_addr < NUM_EDGE_REGS; otherwise no write.
REQ-020 SHALL implement FSM states IDLE, LAUNCH, WAIT, COMPLETE.
REQ-021 IDLE: start high -> LAUNCH; copy all edge registers into snapshot (edge_bus) same edge; busy rises next cycle.
REQ-022 SHALL accept start only in IDLE; start in other states ignored, not queued.
REQ-023 Same-cycle start and wr_ena in IDLE: write SHALL land in edge register, snapshot SHALL capture pre-write value.
REQ-024 LAUNCH: acc_start high one cycle, -> WAIT; WAIT: acc_start low, cycle counter increments.
REQ-025 WAIT with acc_done high: capture acc_return into result_lo/result_hi, clear timeout, -> COMPLETE.
REQ-026 acc_done high in LAUNCH SHALL be treated as in WAIT (capture, -> COMPLETE).
REQ-027 COMPLETE: done high exactly one cycle, busy low same cycle, -> IDLE.
REQ-028 Minimum latency start-to-done SHALL be 3 cycles (acc_done returned first WAIT cycle).
REQ-029 acc_done outside LAUNCH/WAIT SHALL be ignored; results unchanged.
REQ-030 Edge register file SHALL remain writable-blocked only while busy; snapshot held stable LAUNCH through COMPLETE.

Reset
REQ-031 rstb low SHALL immediately force FSM to IDLE, counter to 0, and busy, done, timeout, acc_start, result_lo, result_hi, edge registers, snapshot to 0.
REQ-032 Reset mid-operation SHALL abort without a done pulse; late acc_done after release ignored per REQ-029.

Configuration
REQ-033 Macro EDGCOL_DISPATCH_TIMEOUT_EN defined: WAIT counter reaching TIMEOUT_CYCLES without acc_done SHALL set timeout, leave results unchanged, -> COMPLETE (done pulses).
REQ-034 Macro undefined: no counter, timeout tied 0, WAIT persists until acc_done.

Verification
REQ-035 Write regs 0..5 = 1..6, start, acc_done in first WAIT with acc_return=64'h0000_0001_0000_0000 -> done at cycle 3, result_hi=1, result_lo=0, edge_bus packs 1..6.
REQ-036 start and wr_ena(addr 2, data 0xAA) same cycle -> snapshot reg2 holds old value; edge register 2 = 0xAA after done.
REQ-037 wr_ena during busy (addr 0, 0xFF) and start re-pulsed in WAIT -> reg 0 unchanged, single done pulse only.
REQ-038 TIMEOUT_EN, TIMEOUT_CYCLES=4, acc_done never -> timeout=1, done after WAIT count 4, results stay prior values; next good op clears timeout.
REQ-039 rstb low in WAIT, acc_done one cycle after release -> no done, busy 0, results 0.
REQ-040 NUM_EDGE_REGS=8, wr_addr beyond range impossible; NUM_EDGE_REGS=6 with wr_addr=7 -> no register changes.
